// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bundle widths, bit positions,
// NOP bundles and the hardwired-zero register specifier.
package mips_pkg;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEM2REG  = 0;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  localparam logic [WB_W-1:0] CTL_NOP_WB = '0;
  localparam logic [M_W-1:0]  CTL_NOP_M  = '0;
  localparam logic [EX_W-1:0] CTL_NOP_EX = '0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination matches either
// source field of the instruction in decode. Writes to $0 never hazard.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_memread,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          hz
);

  // Both source fields are compared regardless of opcode (conservative).
  assign hz = ex_memread && (ex_rt != RW'(REG_ZERO)) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on branch flush or load-use
// hazard. Hazard detection and the stall counter exist only with ID_EX_HAZARD_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WB_W-1:0] id_wb,
  input  logic [M_W-1:0]  id_m,
  input  logic [EX_W-1:0] id_ex,
  input  logic [DW-1:0]   id_npc,
  input  logic [DW-1:0]   id_rd1,
  input  logic [DW-1:0]   id_rd2,
  input  logic [DW-1:0]   id_imm,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic            flush,
  output logic [WB_W-1:0] ex_wb,
  output logic [M_W-1:0]  ex_m,
  output logic [EX_W-1:0] ex_ex,
  output logic [DW-1:0]   ex_npc,
  output logic [DW-1:0]   ex_rd1,
  output logic [DW-1:0]   ex_rd2,
  output logic [DW-1:0]   ex_imm,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic            pc_write,
  output logic            if_id_write,
  output logic [15:0]     stall_count
);

  logic [WB_W-1:0] ex_wb_q, ex_wb_d;
  logic [M_W-1:0]  ex_m_q, ex_m_d;
  logic [EX_W-1:0] ex_ex_q, ex_ex_d;
  logic [DW-1:0]   ex_npc_q, ex_npc_d;
  logic [DW-1:0]   ex_rd1_q, ex_rd1_d;
  logic [DW-1:0]   ex_rd2_q, ex_rd2_d;
  logic [DW-1:0]   ex_imm_q, ex_imm_d;
  logic [RW-1:0]   ex_rs_q, ex_rs_d;
  logic [RW-1:0]   ex_rt_q, ex_rt_d;
  logic [RW-1:0]   ex_rd_q, ex_rd_d;

  logic hz;
  logic bub;

`ifdef ID_EX_HAZARD_EN
  logic [15:0] stall_count_q, stall_count_d;

  hazard_detect #(.RW(RW)) u_hazard_detect (
    .ex_memread (ex_m_q[M_MEMREAD]),
    .ex_rt      (ex_rt_q),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hz         (hz)
  );

  // A stall only counts when flush is not overriding it.
  always_comb begin
    stall_count_d = stall_count_q;
    if (hz && !flush && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign hz          = 1'b0;
  assign stall_count = '0;
`endif

  assign bub         = flush | hz;
  assign pc_write    = ~(hz & ~flush);
  assign if_id_write = ~(hz & ~flush);

  // Data and specifiers always load; only the control bundles are squashed.
  always_comb begin
    ex_wb_d  = bub ? CTL_NOP_WB : id_wb;
    ex_m_d   = bub ? CTL_NOP_M  : id_m;
    ex_ex_d  = bub ? CTL_NOP_EX : id_ex;
    ex_npc_d = id_npc;
    ex_rd1_d = id_rd1;
    ex_rd2_d = id_rd2;
    ex_imm_d = id_imm;
    ex_rs_d  = id_rs;
    ex_rt_d  = id_rt;
    ex_rd_d  = id_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wb_q  <= '0;
      ex_m_q   <= '0;
      ex_ex_q  <= '0;
      ex_npc_q <= '0;
      ex_rd1_q <= '0;
      ex_rd2_q <= '0;
      ex_imm_q <= '0;
      ex_rs_q  <= '0;
      ex_rt_q  <= '0;
      ex_rd_q  <= '0;
    end else begin
      ex_wb_q  <= ex_wb_d;
      ex_m_q   <= ex_m_d;
      ex_ex_q  <= ex_ex_d;
      ex_npc_q <= ex_npc_d;
      ex_rd1_q <= ex_rd1_d;
      ex_rd2_q <= ex_rd2_d;
      ex_imm_q <= ex_imm_d;
      ex_rs_q  <= ex_rs_d;
      ex_rt_q  <= ex_rt_d;
      ex_rd_q  <= ex_rd_d;
    end
  end

  assign ex_wb  = ex_wb_q;
  assign ex_m   = ex_m_q;
  assign ex_ex  = ex_ex_q;
  assign ex_npc = ex_npc_q;
  assign ex_rd1 = ex_rd1_q;
  assign ex_rd2 = ex_rd2_q;
  assign ex_imm = ex_imm_q;
  assign ex_rs  = ex_rs_q;
  assign ex_rt  = ex_rt_q;
  assign ex_rd  = ex_rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; expectations follow ID_EX_HAZARD_EN.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
`ifdef ID_EX_HAZARD_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [WB_W-1:0] id_wb;
  logic [M_W-1:0]  id_m;
  logic [EX_W-1:0] id_ex;
  logic [DW-1:0]   id_npc, id_rd1, id_rd2, id_imm;
  logic [RW-1:0]   id_rs, id_rt, id_rd;
  logic            flush;
  logic [WB_W-1:0] ex_wb;
  logic [M_W-1:0]  ex_m;
  logic [EX_W-1:0] ex_ex;
  logic [DW-1:0]   ex_npc, ex_rd1, ex_rd2, ex_imm;
  logic [RW-1:0]   ex_rs, ex_rt, ex_rd;
  logic            pc_write, if_id_write;
  logic [15:0]     stall_count;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
    .id_npc(id_npc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex),
    .ex_npc(ex_npc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [151:0] bus;
    logic [15:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        fl;
    logic [31:0] rd1;
  } stim_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad   = 0;
  logic [2:0]   m_ex_m;
  logic [4:0]   m_ex_rt;
  logic [15:0]  m_cnt;
  logic         exp_pw;
  logic [151:0] obs;

  assign obs = {ex_wb, ex_m, ex_ex, ex_npc, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd};

  function automatic stim_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic fl, input logic [31:0] rd1);
    stim_t s;
    s.wb = wb; s.m = m; s.ex = ex; s.rs = rs; s.rt = rt; s.rd = rd; s.fl = fl; s.rd1 = rd1;
    return s;
  endfunction

  // Drive one decode slot at the falling edge and push its expected EX image.
  task automatic step(input stim_t s);
    exp_t ent;
    logic hz_m, bub;
    @(negedge clk);
    id_wb = s.wb; id_m = s.m; id_ex = s.ex;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
    flush = s.fl; id_rd1 = s.rd1;
    id_npc = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    hz_m = HZ_EN && m_ex_m[1] && (m_ex_rt != 5'd0) && ((m_ex_rt == s.rs) || (m_ex_rt == s.rt));
    bub = s.fl | hz_m;
    exp_pw = !(hz_m && !s.fl);
    ent.bus = {bub ? 2'b00 : s.wb, bub ? 3'b000 : s.m, bub ? 4'b0000 : s.ex,
               id_npc, s.rd1, id_rd2, id_imm, s.rs, s.rt, s.rd};
    ent.cnt = (hz_m && !s.fl && (m_cnt != 16'hFFFF)) ? m_cnt + 16'd1 : m_cnt;
    m_cnt   = ent.cnt;
    m_ex_m  = bub ? 3'b000 : s.m;
    m_ex_rt = s.rt;
    sb.push_back(ent);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ex_m = '0; m_ex_rt = '0; m_cnt = '0;
  endtask

  task automatic test_reset();
    total++;
    if (obs !== '0 || stall_count !== 16'd0 || pc_write !== 1'b1 || if_id_write !== 1'b1) begin
      bad++;
      $display("FAIL reset: ex=%h cnt=%h pw=%b ifid=%b, required all zero / cnt 0 / pw 1",
               obs, stall_count, pc_write, if_id_write);
    end
    $display("reset check: ex=%h cnt=%h pw=%b", obs, stall_count, pc_write);
  endtask

  task automatic test_passthrough();
    stim_t v[$];
    exp_t e;
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 1'b0, 32'h1234));
    v.push_back(mk(2'b01, 3'b001, 4'b0011, 5'd4, 5'd5, 5'd6, 1'b0, 32'hDEADBEEF));
    foreach (v[i]) begin
      step(v[i]);
      total++;
      if (pc_write !== exp_pw || if_id_write !== exp_pw) begin
        bad++;
        $display("FAIL passthrough_pw[%0d]: pw=%b ifid=%b required %b", i, pc_write, if_id_write, exp_pw);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e.bus || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL passthrough[%0d]: ex=%h cnt=%h required ex=%h cnt=%h", i, obs, stall_count, e.bus, e.cnt);
      end
      $display("passthrough[%0d]: ex=%h pw=%b", i, obs, pc_write);
    end
  endtask

  task automatic test_load_use();
    stim_t v[$];
    exp_t e;
    v.push_back(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd8, 5'd0, 1'b0, 32'h1));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd3, 1'b0, 32'h2));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd3, 1'b0, 32'h2));
    v.push_back(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd0, 5'd0, 1'b0, 32'h3));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd0, 5'd0, 5'd7, 1'b0, 32'h4));
    v.push_back(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd9, 5'd0, 1'b0, 32'h5));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd2, 5'd9, 5'd3, 1'b0, 32'h6));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd2, 5'd9, 5'd3, 1'b0, 32'h6));
    foreach (v[i]) begin
      step(v[i]);
      total++;
      if (pc_write !== exp_pw || if_id_write !== exp_pw) begin
        bad++;
        $display("FAIL load_use_pw[%0d]: pw=%b ifid=%b required %b", i, pc_write, if_id_write, exp_pw);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e.bus || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL load_use[%0d]: ex=%h cnt=%h required ex=%h cnt=%h", i, obs, stall_count, e.bus, e.cnt);
      end
      $display("load_use[%0d]: ex_m=%b pw=%b cnt=%0d", i, ex_m, exp_pw, stall_count);
    end
  endtask

  task automatic test_flush_vs_stall();
    stim_t v[$];
    exp_t e;
    v.push_back(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd8, 5'd0, 1'b0, 32'h10));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd8, 5'd8, 5'd3, 1'b1, 32'h11));
    v.push_back(mk(2'b10, 3'b100, 4'b0101, 5'd4, 5'd5, 5'd6, 1'b1, 32'h12));
    v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd4, 5'd5, 5'd6, 1'b0, 32'h13));
    foreach (v[i]) begin
      step(v[i]);
      total++;
      if (pc_write !== exp_pw || if_id_write !== exp_pw) begin
        bad++;
        $display("FAIL flush_pw[%0d]: pw=%b ifid=%b required %b", i, pc_write, if_id_write, exp_pw);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e.bus || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL flush[%0d]: ex=%h cnt=%h required ex=%h cnt=%h", i, obs, stall_count, e.bus, e.cnt);
      end
      $display("flush[%0d]: ex_m=%b pw=%b cnt=%0d", i, ex_m, exp_pw, stall_count);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    stim_t s;
    for (int i = 0; i < 48; i++) begin
      s = mk(2'($urandom), 3'($urandom_range(0, 7)), 4'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom), ($urandom_range(0, 7) == 0), $urandom);
      step(s);
      total++;
      if (pc_write !== exp_pw || if_id_write !== exp_pw) begin
        bad++;
        $display("FAIL b2b_pw[%0d]: pw=%b ifid=%b required %b", i, pc_write, if_id_write, exp_pw);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e.bus || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL b2b[%0d]: ex=%h cnt=%h required ex=%h cnt=%h", i, obs, stall_count, e.bus, e.cnt);
      end
      $display("b2b[%0d]: ex_m=%b pw=%b cnt=%0d", i, ex_m, exp_pw, stall_count);
    end
  endtask

  task automatic test_saturation();
`ifdef ID_EX_HAZARD_EN
    stim_t v[$];
    exp_t e;
    force dut.stall_count_q = 16'hFFFE;
    #1;
    release dut.stall_count_q;
    m_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      v.push_back(mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd8, 5'd0, 1'b0, 32'h20));
      v.push_back(mk(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd3, 1'b0, 32'h21));
    end
    foreach (v[i]) begin
      step(v[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      total++;
      if (obs !== e.bus || stall_count !== e.cnt) begin
        bad++;
        $display("FAIL saturation[%0d]: ex=%h cnt=%h required ex=%h cnt=%h", i, obs, stall_count, e.bus, e.cnt);
      end
      $display("saturation[%0d]: cnt=%h", i, stall_count);
    end
`endif
  endtask

  task automatic test_reset_midstall();
    stim_t s;
    s = mk(2'b11, 3'b010, 4'b0011, 5'd1, 5'd8, 5'd0, 1'b0, 32'h30);
    step(s);
    @(posedge clk); #1;
    void'(sb.pop_front());
    s = mk(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd3, 1'b0, 32'h31);
    step(s);
    rst_n = 1'b0;
    #1;
    model_reset();
    test_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_wb = '0; id_m = '0; id_ex = '0; id_npc = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; flush = 1'b0;
    model_reset();
    #1;
    test_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    test_passthrough();
    test_load_use();
    test_flush_vs_stall();
    test_back_to_back();
    test_saturation();
    test_reset_midstall();
    test_load_use();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
